// File: rtl/flash_led_pkg.sv
// Shared definitions for the flash LED display: mode codes, start patterns
// and small helpers used by the sequencer.
// Ports: none (package).
package flash_led_pkg;

   localparam int LED_W = 16;

   typedef enum logic [1:0] {
      MODE_SHIFT_L  = 2'd0,
      MODE_SHIFT_R  = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_BLINK    = 2'd3
   } mode_e;

   localparam logic [LED_W-1:0] START_SHIFT_L  = 16'h0001;
   localparam logic [LED_W-1:0] START_SHIFT_R  = 16'h8000;
   localparam logic [LED_W-1:0] START_PINGPONG = 16'h0001;
   localparam logic [LED_W-1:0] START_BLINK    = 16'hFFFF;

   // Pattern loaded into the LEDs when a mode is entered.
   function automatic logic [LED_W-1:0] start_pattern(input mode_e m);
      logic [LED_W-1:0] p;
      case (m)
         MODE_SHIFT_L:  p = START_SHIFT_L;
         MODE_SHIFT_R:  p = START_SHIFT_R;
         MODE_PINGPONG: p = START_PINGPONG;
         default:       p = START_BLINK;
      endcase
      return p;
   endfunction

   // Exactly one bit set.
   function automatic logic is_onehot(input logic [LED_W-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/flash_led_seq_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level debounce counter and a
// one-cycle press pulse on the accepted rising level. Reusable for any button.
// Ports: clk, rst (async, active-high), btn_i (raw, async), press_o (1-cycle pulse).
module btn_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   localparam int CNT_W = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             db_q, db_d;
   logic             db_dly_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         db_q     <= db_d;
         db_dly_q <= db_q;
         cnt_q    <= cnt_d;
      end
   end

   // A level change is accepted only after it has differed from the
   // debounced level for DEB_CYCLES consecutive cycles; any agreement
   // in between restarts the count.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Rising edge of the debounced level only; release is ignored.
   assign press_o = db_q & ~db_dly_q;

endmodule

// File: rtl/flash_led_seq_ctrl.sv
// LED animation sequencer: button press cycles SHIFT_L/SHIFT_R/PINGPONG/BLINK,
// each mode stepped by a prescaled tick of TICK_DIV cycles.
// Ports: clk, rst (async, active-high), btn_c (raw button), led[15:0], mode[1:0], step.
module flash_led_seq_ctrl
   import flash_led_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_c,
   output logic [LED_W-1:0] led,
   output logic [1:0]       mode,
   output logic             step
);

   localparam int PS_W = $clog2(TICK_DIV);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

   logic             press;
   logic             step_w;
   logic [PS_W-1:0]  presc_q, presc_d;
   mode_e            mode_q, mode_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             dir_right_q, dir_right_d;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_btn_c (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_c),
      .press_o (press)
   );

   assign step_w = (presc_q == PS_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q     <= '0;
         mode_q      <= MODE_SHIFT_L;
         led_q       <= START_SHIFT_L;
         dir_right_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         mode_q      <= mode_d;
         led_q       <= led_d;
         dir_right_q <= dir_right_d;
      end
   end

   // Press has priority over a coincident step: the new mode starts from its
   // start pattern with a fresh prescaler, so its first step is a full
   // TICK_DIV cycles later.
   always_comb begin
      mode_d      = mode_q;
      led_d       = led_q;
      dir_right_d = dir_right_q;
      presc_d     = step_w ? '0 : presc_q + 1'b1;

      if (press) begin
         case (mode_q)
            MODE_SHIFT_L:  mode_d = MODE_SHIFT_R;
            MODE_SHIFT_R:  mode_d = MODE_PINGPONG;
            MODE_PINGPONG: mode_d = MODE_BLINK;
            default:       mode_d = MODE_SHIFT_L;
         endcase
         led_d       = start_pattern(mode_d);
         presc_d     = '0;
         dir_right_d = 1'b0;
      end else if (step_w) begin
         case (mode_q)
            MODE_SHIFT_L: begin
               led_d = is_onehot(led_q) ? {led_q[LED_W-2:0], led_q[LED_W-1]}
                                        : START_SHIFT_L;
            end
            MODE_SHIFT_R: begin
               led_d = is_onehot(led_q) ? {led_q[0], led_q[LED_W-1:1]}
                                        : START_SHIFT_R;
            end
            MODE_PINGPONG: begin
               // Turn around at the ends without repeating the end value.
               if (!is_onehot(led_q)) begin
                  led_d       = START_PINGPONG;
                  dir_right_d = 1'b0;
               end else if (led_q[LED_W-1]) begin
                  led_d       = 16'h4000;
                  dir_right_d = 1'b1;
               end else if (led_q[0]) begin
                  led_d       = 16'h0002;
                  dir_right_d = 1'b0;
               end else if (dir_right_q) begin
                  led_d = led_q >> 1;
               end else begin
                  led_d = led_q << 1;
               end
            end
            default: begin
               led_d = ~led_q;
            end
         endcase
      end
   end

   assign led  = led_q;
   assign mode = mode_q;
   assign step = step_w;

endmodule

// File: tb/tb_flash_led_seq_ctrl.sv
module tb_flash_led_seq_ctrl;

   localparam int TICK = 4;
   localparam int DEB  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_c = 1'b0;
   logic [15:0] led;
   logic [1:0]  mode;
   logic        step;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   flash_led_seq_ctrl #(
      .TICK_DIV   (TICK),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .btn_c (btn_c),
      .led   (led),
      .mode  (mode),
      .step  (step)
   );

   // Reference model: mode number, lit LED position, pingpong direction and
   // blink phase; the LED word is derived from those. Button acceptance is
   // "DEB consecutive differing samples, two cycles late".
   int m_mode  = 0;
   int m_pos   = 0;
   int m_presc = 0;
   int m_run   = 0;
   bit m_left  = 1'b1;
   bit m_on    = 1'b1;
   bit m_db    = 1'b0;
   bit m_pend  = 1'b0;
   bit m_h0    = 1'b0;
   bit m_h1    = 1'b0;
   bit m_tick;
   bit m_rise;

   function automatic logic [15:0] exp_led();
      if (m_mode == 3) return m_on ? 16'hFFFF : 16'h0000;
      return 16'h0001 << m_pos;
   endfunction

   function automatic logic exp_step();
      return (m_presc == TICK - 1);
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_mode = 0; m_pos = 0; m_presc = 0; m_run = 0;
            m_left = 1'b1; m_on = 1'b1; m_db = 1'b0; m_pend = 1'b0;
            m_h0 = 1'b0; m_h1 = 1'b0;
         end else begin
            m_tick = (m_presc == TICK - 1);
            if (m_pend) begin
               m_mode  = (m_mode + 1) % 4;
               m_presc = 0;
               m_left  = 1'b1;
               m_on    = 1'b1;
               m_pos   = (m_mode == 1) ? 15 : 0;
            end else begin
               m_presc = (m_presc + 1) % TICK;
               if (m_tick) begin
                  case (m_mode)
                     0: m_pos = (m_pos + 1) % 16;
                     1: m_pos = (m_pos + 15) % 16;
                     2: begin
                        if (m_left) begin
                           if (m_pos == 15) begin m_pos = 14; m_left = 1'b0; end
                           else m_pos = m_pos + 1;
                        end else begin
                           if (m_pos == 0) begin m_pos = 1; m_left = 1'b1; end
                           else m_pos = m_pos - 1;
                        end
                     end
                     default: m_on = !m_on;
                  endcase
               end
            end
            m_rise = 1'b0;
            if (m_h1 != m_db) begin
               m_run = m_run + 1;
               if (m_run == DEB) begin
                  m_db   = m_h1;
                  m_run  = 0;
                  m_rise = m_db;
               end
            end else begin
               m_run = 0;
            end
            m_pend = m_rise;
            m_h1   = m_h0;
            m_h0   = btn_c;
         end
      end
   end

   task automatic test_reset();
      rst   = 1'b1;
      btn_c = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({led, mode, step} !== {16'h0001, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: led=%h mode=%0d step=%b, want led=0001 mode=0 step=0",
                  led, mode, step);
      end
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      int steps_seen;
      steps_seen = 0;
      for (int i = 0; i < 72; i++) begin
         @(negedge clk);
         if (step) steps_seen++;
         checks++;
         if ({led, mode, step} !== {exp_led(), 2'(m_mode), exp_step()}) begin
            errors++;
            $display("FAIL free_run cyc %0d: led=%h mode=%0d step=%b, want led=%h mode=%0d step=%b",
                     i, led, mode, step, exp_led(), m_mode, exp_step());
         end
      end
      checks++;
      if (steps_seen != 72 / TICK) begin
         errors++;
         $display("FAIL free_run_step_count: got %0d, want %0d", steps_seen, 72 / TICK);
      end
   endtask

   task automatic test_glitch();
      int start_mode;
      start_mode = m_mode;
      for (int g = 0; g < 5; g++) begin
         int hi;
         hi = $urandom_range(1, 3);
         for (int i = 0; i < hi + 8; i++) begin
            btn_c = (i < hi);
            @(negedge clk);
            checks++;
            if ({led, mode, step} !== {exp_led(), 2'(m_mode), exp_step()}) begin
               errors++;
               $display("FAIL glitch %0d cyc %0d: led=%h mode=%0d step=%b, want led=%h mode=%0d step=%b",
                        g, i, led, mode, step, exp_led(), m_mode, exp_step());
            end
         end
      end
      btn_c = 1'b0;
      checks++;
      if (mode !== 2'(start_mode)) begin
         errors++;
         $display("FAIL glitch_mode: mode=%0d, want %0d", mode, start_mode);
      end
   endtask

   task automatic test_press_latency();
      int first;
      logic [1:0] m0;
      m0    = mode;
      first = 0;
      btn_c = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         if (i == 21) btn_c = 1'b0;
         @(negedge clk);
         if (first == 0 && mode !== m0) begin
            first = i;
            checks++;
            if (led !== 16'h8000 || mode !== 2'd1) begin
               errors++;
               $display("FAIL press_entry: led=%h mode=%0d, want led=8000 mode=1", led, mode);
            end
         end
         checks++;
         if ({led, mode, step} !== {exp_led(), 2'(m_mode), exp_step()}) begin
            errors++;
            $display("FAIL press_latency cyc %0d: led=%h mode=%0d step=%b, want led=%h mode=%0d step=%b",
                     i, led, mode, step, exp_led(), m_mode, exp_step());
         end
      end
      checks++;
      if (first - 1 != DEB + 2) begin
         errors++;
         $display("FAIL press_edge: mode changed at edge %0d, want %0d", first - 1, DEB + 2);
      end
   endtask

   task automatic test_pingpong_blink();
      int target;
      int ends;
      ends = 0;
      for (int t = 2; t <= 4; t++) begin
         target = t % 4;
         for (int p = 0; p < 4 && m_mode != target; p++) begin
            for (int i = 0; i < 16; i++) begin
               btn_c = (i < 8);
               @(negedge clk);
               checks++;
               if ({led, mode, step} !== {exp_led(), 2'(m_mode), exp_step()}) begin
                  errors++;
                  $display("FAIL pp_press cyc %0d: led=%h mode=%0d step=%b, want led=%h mode=%0d step=%b",
                           i, led, mode, step, exp_led(), m_mode, exp_step());
               end
            end
         end
         checks++;
         if (mode !== 2'(target)) begin
            errors++;
            $display("FAIL pp_mode_reach: mode=%0d, want %0d", mode, target);
         end
         for (int i = 0; i < ((target == 2) ? 40 * TICK : 3 * TICK); i++) begin
            @(negedge clk);
            if (step && (led == 16'h8000 || led == 16'h0001)) ends++;
            checks++;
            if ({led, mode, step} !== {exp_led(), 2'(m_mode), exp_step()}) begin
               errors++;
               $display("FAIL pp_run mode %0d cyc %0d: led=%h mode=%0d step=%b, want led=%h mode=%0d step=%b",
                        target, i, led, mode, step, exp_led(), m_mode, exp_step());
            end
         end
      end
      checks++;
      if (ends == 0) begin
         errors++;
         $display("FAIL pp_endpoints: end values seen %0d, want >0", ends);
      end
   endtask

   task automatic test_press_on_step();
      int k;
      k = 0;
      while (m_presc != 1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      btn_c = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         if (i == 10) btn_c = 1'b0;
         @(negedge clk);
         if (i == DEB + 2) begin
            checks++;
            if (step !== 1'b1) begin
               errors++;
               $display("FAIL press_on_step_align: step=%b, want 1", step);
            end
         end
         if (i == DEB + 3) begin
            checks++;
            if (led !== ((m_mode == 1) ? 16'h8000 : (m_mode == 3) ? 16'hFFFF : 16'h0001)
                || step !== 1'b0) begin
               errors++;
               $display("FAIL press_on_step_load: led=%h step=%b, want start pattern of mode %0d, step=0",
                        led, step, m_mode);
            end
         end
         checks++;
         if ({led, mode, step} !== {exp_led(), 2'(m_mode), exp_step()}) begin
            errors++;
            $display("FAIL press_on_step cyc %0d: led=%h mode=%0d step=%b, want led=%h mode=%0d step=%b",
                     i, led, mode, step, exp_led(), m_mode, exp_step());
         end
      end
   endtask

   task automatic test_async_reset();
      int first;
      for (int p = 0; p < 4 && m_mode != 3; p++) begin
         for (int i = 0; i < 16; i++) begin
            btn_c = (i < 8);
            @(negedge clk);
         end
      end
      repeat (5) @(negedge clk);
      checks++;
      if (mode !== 2'd3) begin
         errors++;
         $display("FAIL ar_blink_reach: mode=%0d, want 3", mode);
      end
      btn_c = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({led, mode, step} !== {16'h0001, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: led=%h mode=%0d step=%b, want led=0001 mode=0 step=0",
                  led, mode, step);
      end
      @(negedge clk);
      rst   = 1'b0;
      first = 0;
      for (int i = 1; i <= 30; i++) begin
         if (i == 15) btn_c = 1'b0;
         @(negedge clk);
         if (first == 0 && mode !== 2'd0) first = i;
         checks++;
         if ({led, mode, step} !== {exp_led(), 2'(m_mode), exp_step()}) begin
            errors++;
            $display("FAIL post_reset cyc %0d: led=%h mode=%0d step=%b, want led=%h mode=%0d step=%b",
                     i, led, mode, step, exp_led(), m_mode, exp_step());
         end
      end
      checks++;
      if (first - 1 != DEB + 2) begin
         errors++;
         $display("FAIL post_reset_press_edge: edge %0d, want %0d", first - 1, DEB + 2);
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold == 0) begin
            btn_c = ~btn_c;
            hold  = $urandom_range(1, 12);
         end
         hold--;
         @(negedge clk);
         checks++;
         if ({led, mode, step} !== {exp_led(), 2'(m_mode), exp_step()}) begin
            errors++;
            $display("FAIL random cyc %0d: led=%h mode=%0d step=%b, want led=%h mode=%0d step=%b",
                     i, led, mode, step, exp_led(), m_mode, exp_step());
         end
      end
      btn_c = 1'b0;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_glitch();
      test_press_latency();
      test_pingpong_blink();
      test_press_on_step();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
